uart_rx_oversampler: RTL and testbench



---
 rtl/uart_rx_oversampler.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_oversampler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler: 16x oversampling UART receiver with 3-sample majority vote,
// optional parity, frame/parity/break flags and a valid/ready holding register.
// Optional feature macro: UART_RX_NOISE_FLAG_EN adds noise_err (non-unanimous vote seen).
module uart_rx_oversampler #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       rx,
    input  logic       parity_en,
    input  logic       parity_odd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       break_det,
    output logic       overrun,
    output logic       busy
`ifdef UART_RX_NOISE_FLAG_EN
    ,
    output logic       noise_err
`endif
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] C_M1   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_M    = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_P1   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [2:0]    I_LAST = 3'(DATA_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic [2:0]             state;
    logic [CW-1:0]          cnt;
    logic [2:0]             idx;
    logic                   s0, s1;
    logic                   maj;
    logic                   at_vote, at_wrap;
    logic                   pen_r, podd_r;
    logic [7:0]             fdata;
    logic                   pbit, perr_f;
    logic                   done;
    logic                   fe_n, bd_n;

    assign rx_s    = sync[SYNC_STAGES-1];
    assign maj     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign at_vote = tick && cnt == C_P1;
    assign at_wrap = tick && cnt == C_LAST;
    assign done    = state == STOP && at_vote;
    assign fe_n    = !maj;
    assign bd_n    = fdata == 8'd0 && !(pen_r && pbit) && !maj;
    assign busy    = state != IDLE;

`ifdef UART_RX_NOISE_FLAG_EN
    logic split, noise_f;
    assign split = !(s0 == s1 && s1 == rx_s);
`endif

    // rx metastability synchroniser, idles high
    always_ff @(posedge clk) begin
        if (reset) sync <= '1;
        else       sync <= {sync[SYNC_STAGES-2:0], rx};
    end

    // sample counter, mid-bit captures and frame state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            s0     <= 1'b1;
            s1     <= 1'b1;
            pen_r  <= 1'b0;
            podd_r <= 1'b0;
            fdata  <= '0;
            pbit   <= 1'b0;
            perr_f <= 1'b0;
`ifdef UART_RX_NOISE_FLAG_EN
            noise_f <= 1'b0;
`endif
        end else if (tick) begin
            if (state == IDLE) begin
                if (!rx_s) begin
                    state  <= START;
                    cnt    <= CW'(1);
                    idx    <= '0;
                    pen_r  <= parity_en;
                    podd_r <= parity_odd;
                    fdata  <= '0;
                    pbit   <= 1'b0;
                    perr_f <= 1'b0;
`ifdef UART_RX_NOISE_FLAG_EN
                    noise_f <= 1'b0;
`endif
                end
            end else begin
                cnt <= cnt + CW'(1);
                if (cnt == C_M1) s0 <= rx_s;
                if (cnt == C_M)  s1 <= rx_s;
`ifdef UART_RX_NOISE_FLAG_EN
                if (at_vote && split) noise_f <= 1'b1;
`endif
                case (state)
                    START: begin
                        if (at_vote && maj) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (at_wrap) begin
                            state <= DATA;
                            idx   <= '0;
                        end
                    end
                    DATA: begin
                        if (at_vote) fdata[idx] <= maj;
                        if (at_wrap) begin
                            idx   <= idx + 3'd1;
                            state <= idx == I_LAST ? (pen_r ? PARITY : STOP) : DATA;
                        end
                    end
                    PARITY: begin
                        if (at_vote) begin
                            pbit   <= maj;
                            perr_f <= ^fdata ^ maj ^ podd_r;
                        end
                        if (at_wrap) state <= STOP;
                    end
                    STOP: begin
                        if (at_vote) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // holding register with valid/ready handshake and overrun detection
    always_ff @(posedge clk) begin
        if (reset) begin
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_NOISE_FLAG_EN
            noise_err  <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (done && (!valid || ready)) begin
                data       <= fdata;
                valid      <= 1'b1;
                frame_err  <= fe_n;
                parity_err <= perr_f;
                break_det  <= bd_n;
`ifdef UART_RX_NOISE_FLAG_EN
                noise_err  <= noise_f | split;
`endif
            end else if (done) begin
                overrun <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_oversampler.sv
// tb_uart_rx_oversampler: scoreboard bench; stimulus pushes expected frames, a monitor pops on accept.
module tb_uart_rx_oversampler;
    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       bd;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b1;
    logic       rx = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       ready = 1'b1;
    logic       frame_err, parity_err, break_det, overrun, busy;
`ifdef UART_RX_NOISE_FLAG_EN
    logic       noise_err;
`endif

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   ovr_cnt = 0;

    uart_rx_oversampler dut (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx),
        .parity_en(parity_en), .parity_odd(parity_odd),
        .data(data), .valid(valid), .ready(ready),
        .frame_err(frame_err), .parity_err(parity_err), .break_det(break_det),
        .overrun(overrun), .busy(busy)
`ifdef UART_RX_NOISE_FLAG_EN
        , .noise_err(noise_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic bitp(input logic b);
        rx = b;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic hp, input logic pb, input logic st);
        bitp(1'b0);
        for (int i = 0; i < 8; i++) bitp(d[i]);
        if (hp) bitp(pb);
        bitp(st);
        rx = 1'b1;
        repeat (24) @(posedge clk);
        #1;
    endtask

    // monitor: compare every accepted byte against the scoreboard, count overrun pulses
    always @(negedge clk) begin
        if (!reset && overrun) ovr_cnt++;
        if (!reset && valid && ready) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_valid: got data %0h expected none", data);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("data", {24'd0, data}, {24'd0, e.d});
                check("flags", {29'd0, frame_err, parity_err, break_det}, {29'd0, e.fe, e.pe, e.bd});
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'd0, valid}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_data", {24'd0, data}, 0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        q.push_back('{8'h55, 1'b0, 1'b0, 1'b0});
        send(8'h55, 1'b0, 1'b0, 1'b1);

        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("false_start_busy_hi", {31'd0, busy}, 1);
        rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("false_start_busy_lo", {31'd0, busy}, 0);

        parity_en = 1'b1;
        q.push_back('{8'hA5, 1'b0, 1'b1, 1'b0});
        send(8'hA5, 1'b1, 1'b1, 1'b1);
        parity_en = 1'b0;

        q.push_back('{8'h3C, 1'b1, 1'b0, 1'b0});
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        q.push_back('{8'h00, 1'b1, 1'b0, 1'b1});
        send(8'h00, 1'b0, 1'b0, 1'b0);

        ready = 1'b0;
        q.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
        send(8'h11, 1'b0, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b0, 1'b1);
        check("overrun_pulses", ovr_cnt, 1);
        check("held_valid", {31'd0, valid}, 1);
        check("held_data", {24'd0, data}, 8'h11);
        ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("valid_after_accept", {31'd0, valid}, 0);

        bitp(1'b0);
        for (int i = 0; i < 3; i++) bitp(1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("busy_mid_frame", {31'd0, busy}, 1);
        reset = 1'b1;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {19'd0, data, valid, frame_err, parity_err, break_det, overrun, busy}, 0);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        q.push_back('{8'h7E, 1'b0, 1'b0, 1'b0});
        send(8'h7E, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_empty", q.size(), 0);
        check("final_overruns", ovr_cnt, 1);
        check("final_idle", {30'd0, busy, valid}, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
